// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: widths, the opcode
// mnemonics, FSM states and the program counter load selects.
package instr_sequencer_pkg;

  localparam int PC_W   = 10;
  localparam int OP_W   = 5;
  localparam int IMM_W  = 5;
  localparam int INST_W = OP_W + IMM_W;

  // Opcodes 18..31 are undefined and execute as no-ops.
  typedef enum logic [OP_W-1:0] {
    oLSR   = 5'd0,
    oRSR   = 5'd1,
    oMOVER = 5'd2,
    oMOVEA = 5'd3,
    oXOR   = 5'd4,
    oRXOR  = 5'd5,
    oADDI  = 5'd6,
    oAND   = 5'd7,
    oANDI  = 5'd8,
    oADD   = 5'd9,
    oSUB   = 5'd10,
    oLUT   = 5'd11,
    oLOAD  = 5'd12,
    oSTORE = 5'd13,
    oBEQ   = 5'd14,
    oBLT   = 5'd15,
    oJUMP  = 5'd16,
    oHALT  = 5'd17
  } op_mne;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    MEMWAIT = 3'd4,
    WBACK   = 3'd5,
    HALTED  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,
    PC_CLEAR = 3'd1,
    PC_INC   = 3'd2,
    PC_REL   = 3'd3,
    PC_PAGE  = 3'd4
  } pc_sel_t;

  function automatic logic writes_reg(input logic [OP_W-1:0] opc);
    case (opc)
      oLSR, oRSR, oMOVER, oMOVEA, oXOR, oRXOR, oAND, oANDI,
      oADD, oADDI, oSUB, oLUT, oLOAD: writes_reg = 1'b1;
      default:                        writes_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_ctr.sv
// Program counter register: hold, clear, increment, signed relative step,
// or absolute load within the current 32-word page. Wraps modulo 1024.
module instr_sequencer_prog_ctr
  import instr_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  pc_sel_t          sel,
  input  logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  pc
);

  logic [PC_W-1:0] imm_sext;

  assign imm_sext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else begin
      case (sel)
        PC_CLEAR: pc <= '0;
        PC_INC:   pc <= pc + PC_W'(1);
        PC_REL:   pc <= pc + imm_sext;
        PC_PAGE:  pc <= {pc[PC_W-1:IMM_W], imm};
        default:  pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer. The strobes are single-cycle pulses with
// no handshake: the ALU/memory must act in the cycle a strobe is high.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [INST_W-1:0] inst_in,
  input  logic              zero,
  output logic [PC_W-1:0]   pc,
  output logic [OP_W-1:0]   op,
  output logic [IMM_W-1:0]  imm,
  output logic              reg_wr_en,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic              done,
  output state_t            state
);

  state_t            state_q;
  state_t            state_d;
  logic [INST_W-1:0] inst_q;
  logic              zero_q;
  pc_sel_t           pc_sel;

  instr_sequencer_prog_ctr prog_ctr (
    .clk (clk),
    .rst (rst),
    .sel (pc_sel),
    .imm (imm),
    .pc  (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q <= '0;
      op     <= '0;
      imm    <= '0;
      zero_q <= 1'b0;
    end else begin
      if (state_q == FETCH) inst_q <= inst_in;
      if (state_q == DECODE) begin
        op  <= inst_q[INST_W-1:IMM_W];
        imm <= inst_q[IMM_W-1:0];
      end
      if (state_q == EXEC) zero_q <= zero;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: if (start) state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC: begin
        case (op)
          oLOAD:   state_d = MEMWAIT;
          oSTORE:  state_d = FETCH;
          oHALT:   state_d = HALTED;
          default: state_d = WBACK;
        endcase
      end
      MEMWAIT: state_d = WBACK;
      WBACK:   state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode the live state so an asynchronous reset drops them at once.
  always_comb begin
    reg_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    pc_sel    = PC_HOLD;
    case (state_q)
      IDLE, HALTED: if (start) pc_sel = PC_CLEAR;
      EXEC: begin
        if (op == oLOAD) begin
          mem_rd_en = 1'b1;
        end else if (op == oSTORE) begin
          mem_wr_en = 1'b1;
          pc_sel    = PC_INC;
        end
      end
      WBACK: begin
        reg_wr_en = writes_reg(op);
        case (op)
          oBEQ, oBLT: pc_sel = zero_q ? PC_REL : PC_INC;
          oJUMP:      pc_sel = PC_PAGE;
          default:    pc_sel = PC_INC;
        endcase
      end
      default: pc_sel = PC_HOLD;
    endcase
  end

  assign done  = (state_q == HALTED);
  assign state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a ROM model feeds instructions, the
// driver queues expected events and a negedge monitor compares DUT events.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam logic [1:0] K_F = 2'd0;
  localparam logic [1:0] K_E = 2'd1;
  localparam logic [1:0] K_W = 2'd2;
  localparam logic [1:0] K_H = 2'd3;
  localparam logic [9:0] HALT_W = {5'd17, 5'd0};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] inst_in;
  logic       zero;
  logic [9:0] pc;
  logic [4:0] op;
  logic [4:0] imm;
  logic       reg_wr_en, mem_rd_en, mem_wr_en, done;
  state_t     state;

  logic [9:0]  rom [1024];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inst_in   (inst_in),
    .zero      (zero),
    .pc        (pc),
    .op        (op),
    .imm       (imm),
    .reg_wr_en (reg_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .done      (done),
    .state     (state)
  );

  // Clock and ROM model
  always #5 clk = ~clk;
  always_comb inst_in = rom[pc];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ev(input logic [1:0] kind, input logic [9:0] epc,
                                     input logic [4:0] eop, input logic [4:0] eimm,
                                     input logic [2:0] stb, input logic [3:0] lat);
    return {kind, epc, eop, eimm, stb, lat, 3'b000};
  endfunction

  task automatic push_f(input logic [9:0] epc, input logic [3:0] lat);
    exp_q.push_back(ev(K_F, epc, 5'd0, 5'd0, 3'b000, lat));
  endtask
  task automatic push_e(input logic [4:0] eop, input logic [4:0] eimm, input logic [2:0] stb);
    exp_q.push_back(ev(K_E, 10'd0, eop, eimm, stb, 4'd0));
  endtask
  task automatic push_w(input logic [2:0] stb);
    exp_q.push_back(ev(K_W, 10'd0, 5'd0, 5'd0, stb, 4'd0));
  endtask
  task automatic push_h(input logic [9:0] epc);
    exp_q.push_back(ev(K_H, epc, 5'd0, 5'd0, 3'b000, 4'd1));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = HALT_W;
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    repeat (n) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(done), 32'd1);
  endtask

  // Scoreboard monitor: one event per FETCH/EXEC/WBACK cycle and HALTED entry
  logic [2:0]  m_stb;
  logic [3:0]  lat_cnt = 4'd0;
  logic [31:0] m_act, m_exp;
  logic        m_have;
  state_t      prev_st = IDLE;

  always @(negedge clk) begin
    m_have = 1'b0;
    m_act  = '0;
    m_stb  = {reg_wr_en, mem_rd_en, mem_wr_en};
    if (rst) begin
      lat_cnt = 4'd0;
    end else begin
      check("strobe_onehot", 32'($countones(m_stb) <= 1), 32'd1);
      if (m_stb != 3'b000 && state != EXEC && state != WBACK) begin
        total++;
        bad++;
        $display("FAIL strobe_state: got strobes %b in state %0d expected none", m_stb, state);
      end
      case (state)
        FETCH: begin
          m_act = ev(K_F, pc, 5'd0, 5'd0, 3'b000, lat_cnt);
          m_have = 1'b1;
          lat_cnt = 4'd1;
        end
        EXEC: begin
          m_act = ev(K_E, 10'd0, op, imm, m_stb, 4'd0);
          m_have = 1'b1;
          lat_cnt++;
        end
        WBACK: begin
          m_act = ev(K_W, 10'd0, 5'd0, 5'd0, m_stb, 4'd0);
          m_have = 1'b1;
          lat_cnt++;
        end
        DECODE, MEMWAIT: lat_cnt++;
        HALTED: begin
          if (prev_st != HALTED) begin
            m_act = ev(K_H, pc, 5'd0, 5'd0, 3'b000, {3'b000, done});
            m_have = 1'b1;
          end
          lat_cnt = 4'd0;
        end
        default: lat_cnt = 4'd0;
      endcase
      if (m_have) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got event %h expected none", m_act);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_act !== m_exp) begin
            bad++;
            $display("FAIL sb_event: got %h expected %h (kind,pc,op,imm,stb,lat)", m_act, m_exp);
          end
        end
      end
    end
    prev_st = state;
  end

  // Directed stimulus
  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    zero = 1'b0;
    clear_rom();
    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_imm", 32'(imm), 32'd0);
    check("rst_strobes", 32'({reg_wr_en, mem_rd_en, mem_wr_en}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // ADDI 0x0C3 then HALT; start held 3 cycles to show it is ignored mid-instruction
    rom[0] = 10'h0C3;
    rom[1] = HALT_W;
    push_f(10'd0, 4'd0); push_e(5'd6, 5'd3, 3'b000); push_w(3'b100);
    push_f(10'd1, 4'd4); push_e(oHALT, 5'd0, 3'b000); push_h(10'd1);
    pulse_start(3);
    wait_halt(100);
    repeat (20) begin
      @(negedge clk);
      check("halt_pc_frozen", 32'(pc), 32'd1);
      check("halt_done", 32'(done), 32'd1);
    end

    // JUMP to 10, BEQ -2 taken -> 8 (HALT)
    clear_rom();
    rom[0]  = {5'd16, 5'd10};
    rom[10] = {5'd14, 5'h1E};
    zero = 1'b1;
    push_f(10'd0, 4'd0); push_e(oJUMP, 5'd10, 3'b000); push_w(3'b000);
    push_f(10'd10, 4'd4); push_e(oBEQ, 5'h1E, 3'b000); push_w(3'b000);
    push_f(10'd8, 4'd4); push_e(oHALT, 5'd0, 3'b000); push_h(10'd8);
    start = 1'b1;
    @(negedge clk);
    check("restart_state", 32'(state), 32'(FETCH));
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_done", 32'(done), 32'd0);
    start = 1'b0;
    wait_halt(100);

    // Same with zero=0: BEQ falls to 11, BLT +3 not taken -> 12 (HALT)
    rom[11] = {5'd15, 5'd3};
    zero = 1'b0;
    push_f(10'd0, 4'd0); push_e(oJUMP, 5'd10, 3'b000); push_w(3'b000);
    push_f(10'd10, 4'd4); push_e(oBEQ, 5'h1E, 3'b000); push_w(3'b000);
    push_f(10'd11, 4'd4); push_e(oBLT, 5'd3, 3'b000); push_w(3'b000);
    push_f(10'd12, 4'd4); push_e(oHALT, 5'd0, 3'b000); push_h(10'd12);
    pulse_start(1);
    wait_halt(100);

    // LOAD then STORE
    clear_rom();
    rom[0] = {5'd12, 5'd4};
    rom[1] = {5'd13, 5'd5};
    push_f(10'd0, 4'd0); push_e(oLOAD, 5'd4, 3'b010); push_w(3'b100);
    push_f(10'd1, 4'd5); push_e(oSTORE, 5'd5, 3'b001);
    push_f(10'd2, 4'd3); push_e(oHALT, 5'd0, 3'b000); push_h(10'd2);
    pulse_start(1);
    wait_halt(100);

    // BEQ -1 from 0 -> 1023, undefined op at 1023 wraps to 0, BEQ not taken -> 1
    clear_rom();
    rom[0]    = {5'd14, 5'h1F};
    rom[1023] = {5'h1F, 5'h0A};
    zero = 1'b1;
    push_f(10'd0, 4'd0); push_e(oBEQ, 5'h1F, 3'b000); push_w(3'b000);
    push_f(10'd1023, 4'd4); push_e(5'h1F, 5'h0A, 3'b000); push_w(3'b000);
    push_f(10'd0, 4'd4); push_e(oBEQ, 5'h1F, 3'b000); push_w(3'b000);
    push_f(10'd1, 4'd4); push_e(oHALT, 5'd0, 3'b000); push_h(10'd1);
    pulse_start(1);
    n = 0;
    while (!(state == EXEC && pc == 10'd1023) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_1023", 32'(pc), 32'd1023);
    zero = 1'b0;
    wait_halt(100);

    // Chain of BEQ -16 from 0 down to 688, BEQ -11 to 0x2A5, JUMP 7 -> 0x2A7
    clear_rom();
    zero = 1'b1;
    rom[0] = {5'd14, 5'h10};
    for (int k = 1; k <= 20; k++) rom[1024 - 16 * k] = {5'd14, 5'h10};
    rom[688]    = {5'd14, 5'h15};
    rom[10'h2A5] = {5'd16, 5'd7};
    push_f(10'd0, 4'd0); push_e(oBEQ, 5'h10, 3'b000); push_w(3'b000);
    for (int k = 1; k <= 20; k++) begin
      push_f(10'(1024 - 16 * k), 4'd4); push_e(oBEQ, 5'h10, 3'b000); push_w(3'b000);
    end
    push_f(10'd688, 4'd4); push_e(oBEQ, 5'h15, 3'b000); push_w(3'b000);
    push_f(10'h2A5, 4'd4); push_e(oJUMP, 5'd7, 3'b000); push_w(3'b000);
    push_f(10'h2A7, 4'd4); push_e(oHALT, 5'd0, 3'b000); push_h(10'h2A7);
    pulse_start(1);
    wait_halt(300);

    // Reset between edges during EXEC of a LOAD
    clear_rom();
    zero = 1'b0;
    rom[0] = {5'd12, 5'd4};
    push_f(10'd0, 4'd0);
    pulse_start(1);
    n = 0;
    while (state != EXEC && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_exec", 32'(state), 32'(EXEC));
    #1 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'(IDLE));
    check("arst_op", 32'(op), 32'd0);
    check("arst_imm", 32'(imm), 32'd0);
    check("arst_pc", 32'(pc), 32'd0);
    check("arst_strobes", 32'({reg_wr_en, mem_rd_en, mem_wr_en}), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_after_rst", 32'(state), 32'(IDLE));
    end
    rom[0] = HALT_W;
    push_f(10'd0, 4'd0); push_e(oHALT, 5'd0, 3'b000); push_h(10'd0);
    pulse_start(1);
    wait_halt(100);
    @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
